mode_counter: RTL
=================

// Module: mode_counter
// PURPOSE
//   Parametrised modulo counter: next generation of the fixed-width LED blink counter.
//   - Programmable modulus, up/down direction, parallel load.
//   - Free-run or one-shot mode.
//   - Terminal-count pulse plus a 50%-duty toggle output (COut) that drives LEDs directly.
//   - Sits between board top levels and LEDs, timers or pacing logic.
// PARAMETERS
//   WIDTH      24        counter width in bits
//   MODULUS    2**24     count length; TOP = MODULUS-1; legal range 2..2**WIDTH
//   AUTO_START 1         1: leave reset in RUN (blinker use); 0: leave reset in IDLE
//   PRESCALE   1000      divide ratio; used only when MODE_COUNTER_PRESCALE_EN is defined
// PORTS
//   Clk      in   1      clock; all logic on the rising edge
//   Rst_n    in   1      asynchronous reset, active-low
//   Clr      in   1      sync clear: Count <= start value, state <= IDLE
//   Start    in   1      IDLE/DONE -> RUN; Count <= start value
//   En       in   1      count enable, gated per cycle
//   Dir      in   1      0 = up, 1 = down; sampled every enabled cycle
//   OneShot  in   1      0 = wrap at terminal; 1 = stop at terminal
//   Load     in   1      sync parallel load
//   LoadVal  in   WIDTH  load value; values > TOP saturate to TOP
//   Count    out  WIDTH  current count
//   Tc       out  1      registered one-cycle terminal-count pulse
//   COut     out  1      toggles on every terminal event
//   Busy     out  1      state == RUN
//   Done     out  1      state == DONE
// BEHAVIOUR
//   Reset (Rst_n low, asynchronous):
//     Count=0, Tc=0, COut=0, Done=0.
//     State = RUN if AUTO_START, else IDLE.
//   Start value: 0 when Dir=0, TOP when Dir=1.
//   Terminal: Count==TOP when Dir=0, Count==0 when Dir=1.
//   States: IDLE, RUN, DONE. Count changes only in RUN with En=1 (and prescale tick).
//   Priority per cycle: Clr > Load > Start > count.
//   Load:
//     Count <= min(LoadVal, TOP) in any state.
//     RUN stays RUN; IDLE stays IDLE; DONE -> IDLE.
//   RUN, enabled, not terminal: Count +/- 1.
//   RUN, enabled, terminal:
//     - Tc=1 in the following cycle; COut toggles on the same edge.
//     - OneShot=0: Count <= start value, stay in RUN.
//     - OneShot=1: Count holds, state -> DONE.
//   DONE:
//     - Count frozen, Done=1.
//     - Start restarts from start value; Clr -> IDLE.
//     - Terminal does not retrigger Tc.
//   Tc is 0 in every other cycle. Clr/Load/Start never pulse Tc or toggle COut.
//   Dir change mid-count: takes effect on the next enabled cycle, no skipped or repeated value.
//     Example: up at 5 -> 6, then Dir=1 -> 5.
//   Count never leaves 0..TOP. Arithmetic is WIDTH bits. No wrap through 2**WIDTH unless MODULUS=2**WIDTH.
//   Reset mid-operation: immediate return to reset values; no pending Tc survives.
// CONFIGURATION
//   MODE_COUNTER_PRESCALE_EN defined:
//     - Internal ceil(log2 PRESCALE)-bit prescaler counts En cycles.
//     - Count advances only on every PRESCALE-th enabled RUN cycle.
//     - Prescaler is cleared by reset, Clr, Load and Start, and frozen when En=0.
//   Undefined:
//     - Prescaler absent; tick is constant 1; PRESCALE is ignored.
// TESTING (WIDTH=4, MODULUS=10, AUTO_START=1 unless stated)
//   1. Assert Rst_n=0 mid-run with Count=6, COut=1
//      -> immediately Count=0, COut=0, Tc=0, Done=0, Busy=1.
//   2. En=1, Dir=0, OneShot=0
//      -> Count 0..9,0,...; Tc high only with Count=0 after 9; COut toggles every 10 cycles.
//   3. Clr, then Dir=1, OneShot=1, Start
//      -> 9..0, holds at 0, Done=1, single Tc; then Start -> 9, Busy=1.
//   4. Load=1, LoadVal=7 with Start=1, En=1 same cycle -> Count=7.
//      LoadVal=13 -> Count=9. Load in DONE -> IDLE.
//   5. En=0 for 5 cycles at Count=3 -> Count stays 3.
//      Dir flips 0->1 at Count=5 -> next value 4.
//   6. With MODE_COUNTER_PRESCALE_EN, PRESCALE=3
//      -> Count advances every 3rd enabled cycle; Load resets the phase.
//      Without the macro -> Count advances every enabled cycle.

Source files
------------

// File: rtl/mode_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : mode_counter_if
// Description : Control/status bundle for mode_counter (controller = master).
// Revision    : 1.0 - initial release
// ============================================================================
interface mode_counter_if #(
  parameter int WIDTH = 24
);
  logic             clr;
  logic             start;
  logic             en;
  logic             dir;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] loadval;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output clr, start, en, dir, oneshot, load, loadval,
    input  count, tc, cout, busy, done
  );

  modport slave (
    input  clr, start, en, dir, oneshot, load, loadval,
    output count, tc, cout, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
// Module      : mode_counter
// Description : Modulo counter with load, up/down, one-shot, Tc pulse and
//               50%-duty toggle output. Define MODE_COUNTER_PRESCALE_EN to
//               insert a divide-by-PRESCALE enable prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_counter #(
  parameter int              WIDTH      = 24,
  parameter longint unsigned MODULUS    = 64'd1 << 24,
  parameter bit              AUTO_START = 1'b1,
  parameter int              PRESCALE   = 1000
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mode_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] c_top = WIDTH'(MODULUS - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_cout;

  logic [WIDTH-1:0] w_start_val;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_terminal;
  logic             w_tick;

  assign w_start_val = bus.dir ? c_top : '0;
  assign w_load_sat  = (bus.loadval > c_top) ? c_top : bus.loadval;
  assign w_terminal  = bus.dir ? (r_count == '0) : (r_count == c_top);

`ifdef MODE_COUNTER_PRESCALE_EN
  localparam int                 c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

  logic [c_pre_w-1:0] r_pre;

  assign w_tick = (r_pre == c_pre_last);

  // Phase restarts on any event that re-seeds the count; holds while En is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (bus.clr || bus.load || bus.start) begin
      r_pre <= '0;
    end else if (r_state == ST_RUN && bus.en) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end
`else
  logic w_unused_prescale;

  assign w_unused_prescale = 1'(PRESCALE);
  assign w_tick            = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= AUTO_START ? ST_RUN : ST_IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (bus.clr) begin
        r_count <= w_start_val;
        r_state <= ST_IDLE;
      end else if (bus.load) begin
        r_count <= w_load_sat;
        if (r_state == ST_DONE) begin
          r_state <= ST_IDLE;
        end
      end else if (bus.start) begin
        r_count <= w_start_val;
        r_state <= ST_RUN;
      end else if (r_state == ST_RUN && bus.en && w_tick) begin
        if (w_terminal) begin
          r_tc   <= 1'b1;
          r_cout <= ~r_cout;
          // One-shot freezes on the terminal value; free-run re-seeds.
          if (bus.oneshot) begin
            r_state <= ST_DONE;
          end else begin
            r_count <= w_start_val;
          end
        end else begin
          r_count <= bus.dir ? r_count - 1'b1 : r_count + 1'b1;
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.cout  = r_cout;
  assign bus.busy  = (r_state == ST_RUN);
  assign bus.done  = (r_state == ST_DONE);

endmodule
`default_nettype wire
